// File: rtl/motor_pkg.sv
// motor_pkg: shared encodings for the motor command sequencer.
// Direction codes match the downstream direction decoder; the state codes are
// kept as plain localparams so that legacy tooling sees simple 2-bit constants.
package motor_pkg;

    // Direction codes presented on dir_out (dir_out[1] -> in1, dir_out[0] -> in0)
    typedef enum logic [1:0] {
        DIR_SPIN_R = 2'd0,  // right forward, left reverse
        DIR_SPIN_L = 2'd1,  // left forward, right reverse
        DIR_FWD    = 2'd2,  // both forward
        DIR_REV    = 2'd3   // both reverse
    } dir_e;

    // Sequencer states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_DEAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;

endpackage

// File: rtl/motor_pwm_gen.sv
// motor_pwm_gen: free-running PWM counter with duty compare and a
// period-boundary flag. The counter sits at zero whenever the sequencer is not
// going to be in RUN next cycle, and restarts from zero on a command replacement.
module motor_pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run_i,      // sequencer is in RUN next cycle
    input  logic                restart_i,  // force count back to 0
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                on_o,       // counter below duty
    output logic                wrap_o      // last cycle of the PWM period
);

    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] cnt_d;

    // Next count: advance while running, otherwise hold at the period start
    // NOTE: every always_comb output is assigned on all paths (here via a single
    // expression) so no latch is inferred.
    always_comb begin
        cnt_d = (run_i && !restart_i) ? cnt_q + PWM_BITS'(1) : '0;
    end

    // Counter register with synchronous reset
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign on_o   = (cnt_q < duty_i);
    assign wrap_o = &cnt_q;

endmodule

// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer: accepts motion commands over valid/ready and drives the
// direction decoder plus a PWM-gated bridge enable. Any direction change, and
// any stop, passes through a bridge-off dead time first.
// Optional feature: define MOTOR_SEQ_RAMP_EN to ramp the effective duty by
// RAMP_STEP per PWM period instead of applying the commanded duty at once.
module motor_cmd_sequencer
    import motor_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int DUR_BITS    = 16,
    parameter int DEAD_CYCLES = 64,
    parameter int RAMP_STEP   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_dir,
    input  logic [PWM_BITS-1:0] cmd_duty,
    input  logic [DUR_BITS-1:0] cmd_periods,
    input  logic                stop,
    output logic [1:0]          dir_out,
    output logic                drive_en,
    output logic                busy,
    output logic                done
);

    localparam int                DEAD_W    = $clog2(DEAD_CYCLES + 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES);

    state_t              state_q, state_d;
    logic [1:0]          dir_q, dir_d;          // direction driven to the decoder
    logic [1:0]          tgt_dir_q, tgt_dir_d;  // latched command direction
    logic [PWM_BITS-1:0] duty_q, duty_d;        // latched command duty (target)
    logic [DUR_BITS-1:0] periods_q, periods_d;  // latched run length, 0 = continuous
    logic [DUR_BITS-1:0] rem_q, rem_d;          // periods left in the current run
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic                stop_pend_q, stop_pend_d;
    logic                done_q, done_d;

    logic                accept;
    logic                restart;    // pwm counter back to 0 this edge
    logic                enter_run;  // RUN entered from IDLE or DEAD
    logic                pwm_on;
    logic                pwm_wrap;
    logic [PWM_BITS-1:0] duty_eff;

    assign cmd_ready = (state_q != ST_DEAD) && !stop;
    assign accept    = cmd_valid && cmd_ready;

    // Command latching and IDLE/DEAD/RUN sequencing
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        tgt_dir_d   = tgt_dir_q;
        duty_d      = duty_q;
        periods_d   = periods_q;
        rem_d       = rem_q;
        dead_d      = dead_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        restart     = 1'b0;
        enter_run   = 1'b0;

        if (accept) begin
            tgt_dir_d = cmd_dir;
            duty_d    = cmd_duty;
            periods_d = cmd_periods;
        end

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (state_q == ST_RUN && stop) begin
                    // Abort: bridge off for the dead time, then back to IDLE
                    state_d     = ST_DEAD;
                    dead_d      = DEAD_LOAD;
                    stop_pend_d = 1'b1;
                end else if (accept) begin
                    if (cmd_dir == dir_q) begin
                        // Same polarity: start (or replace) immediately
                        state_d   = ST_RUN;
                        rem_d     = cmd_periods;
                        restart   = 1'b1;
                        enter_run = (state_q == ST_IDLE);
                    end else begin
                        state_d = ST_DEAD;
                        dead_d  = DEAD_LOAD;
                    end
                end else if (state_q == ST_RUN && pwm_wrap && periods_q != '0) begin
                    if (rem_q <= DUR_BITS'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d = rem_q - DUR_BITS'(1);
                    end
                end
            end
            ST_DEAD: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (dead_q <= DEAD_W'(1)) begin
                    if (stop_pend_q || stop) begin
                        state_d     = ST_IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        // New polarity is applied on the same edge RUN starts
                        state_d   = ST_RUN;
                        dir_d     = tgt_dir_q;
                        rem_d     = periods_q;
                        restart   = 1'b1;
                        enter_run = 1'b1;
                    end
                end else begin
                    dead_d = dead_q - DEAD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset drops any command in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= '0;
            tgt_dir_q   <= '0;
            duty_q      <= '0;
            periods_q   <= '0;
            rem_q       <= '0;
            dead_q      <= '0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            tgt_dir_q   <= tgt_dir_d;
            duty_q      <= duty_d;
            periods_q   <= periods_d;
            rem_q       <= rem_d;
            dead_q      <= dead_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
        end
    end

`ifdef MOTOR_SEQ_RAMP_EN
    logic [PWM_BITS-1:0] duty_eff_q, duty_eff_d;

    // One ramp step from cur toward tgt, never overshooting the target
    function automatic logic [PWM_BITS-1:0] ramp_toward(input logic [PWM_BITS-1:0] cur,
                                                        input logic [PWM_BITS-1:0] tgt);
        logic [PWM_BITS:0] step;
        logic [PWM_BITS:0] gap;
        step = (PWM_BITS + 1)'(RAMP_STEP);
        gap  = (cur < tgt) ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
        if (gap <= step) begin
            return tgt;
        end
        return (cur < tgt) ? cur + step[PWM_BITS-1:0] : cur - step[PWM_BITS-1:0];
    endfunction

    // Effective duty: zero on fresh RUN entry, one step per completed period
    always_comb begin
        duty_eff_d = duty_eff_q;
        if (enter_run) begin
            duty_eff_d = '0;
        end else if (state_q == ST_RUN && state_d == ST_RUN && !restart && pwm_wrap) begin
            duty_eff_d = ramp_toward(duty_eff_q, duty_q);
        end
    end

    // Effective duty register
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_eff_q <= '0;
        end else begin
            duty_eff_q <= duty_eff_d;
        end
    end

    assign duty_eff = duty_eff_q;
`else
    logic unused_ramp;

    assign duty_eff    = duty_q;
    assign unused_ramp = enter_run ^ (RAMP_STEP != 0);
`endif

    motor_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk       (clk),
        .reset     (reset),
        .run_i     (state_d == ST_RUN),
        .restart_i (restart),
        .duty_i    (duty_eff),
        .on_o      (pwm_on),
        .wrap_o    (pwm_wrap)
    );

    assign drive_en = (state_q == ST_RUN) && pwm_on;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign dir_out  = dir_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// tb_motor_cmd_sequencer: scenario tasks compare every cycle of dir_out,
// drive_en, busy, done and cmd_ready against a per-cycle expectation queue built
// from the command timing rules (dead time, periods x 2^PWM_BITS run, done).
// Build with MOTOR_SEQ_RAMP_EN to exercise the ramp variant.
module tb_motor_cmd_sequencer;
    import motor_pkg::*;

    localparam int PWM_BITS    = 4;
    localparam int DUR_BITS    = 8;
    localparam int DEAD_CYCLES = 8;
    localparam int RAMP_STEP   = 4;
    localparam int PERIOD      = 1 << PWM_BITS;
`ifdef MOTOR_SEQ_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_dir;
    logic [PWM_BITS-1:0] cmd_duty;
    logic [DUR_BITS-1:0] cmd_periods;
    logic                stop;
    logic [1:0]          dir_out;
    logic                drive_en;
    logic                busy;
    logic                done;

    int         checks = 0;
    int         errors = 0;
    logic [5:0] exp_q[$];   // {dir_out, drive_en, busy, done, cmd_ready} per cycle
    logic [1:0] m_dir;      // direction the bridge currently has
    int         m_eff;      // effective duty of the period in progress

    motor_cmd_sequencer #(
        .PWM_BITS    (PWM_BITS),
        .DUR_BITS    (DUR_BITS),
        .DEAD_CYCLES (DEAD_CYCLES),
        .RAMP_STEP   (RAMP_STEP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_dir     (cmd_dir),
        .cmd_duty    (cmd_duty),
        .cmd_periods (cmd_periods),
        .stop        (stop),
        .dir_out     (dir_out),
        .drive_en    (drive_en),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: expectation builders ----------------
    function automatic void push(logic [1:0] d, logic en, logic bz, logic dn, logic rdy);
        exp_q.push_back({d, en, bz, dn, rdy});
    endfunction

    function automatic int ramp_next(int cur, int tgt);
        if (!RAMP) return tgt;
        if (cur < tgt) return (cur + RAMP_STEP > tgt) ? tgt : cur + RAMP_STEP;
        if (cur > tgt) return (cur - RAMP_STEP < tgt) ? tgt : cur - RAMP_STEP;
        return cur;
    endfunction

    function automatic void push_dead(logic [1:0] d);
        for (int i = 0; i < DEAD_CYCLES; i++) push(d, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic void push_run(logic [1:0] d, int tgt, int nper, bit with_done);
        for (int p = 0; p < nper; p++) begin
            for (int k = 0; k < PERIOD; k++) push(d, k < m_eff, 1'b1, 1'b0, 1'b1);
            m_eff = ramp_next(m_eff, tgt);
        end
        if (with_done) push(d, 1'b0, 1'b0, 1'b1, 1'b1);
    endfunction

    function automatic void push_partial(logic [1:0] d, int n);
        for (int k = 0; k < n; k++) push(d, k < m_eff, 1'b1, 1'b0, 1'b1);
    endfunction

    task automatic drive_cmd(input logic [1:0] d, input int duty, input int per);
        cmd_valid   = 1'b1;
        cmd_dir     = d;
        cmd_duty    = PWM_BITS'(duty);
        cmd_periods = DUR_BITS'(per);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        logic [5:0] obs;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        stop      = 1'b0;
        cmd_dir   = '0;
        cmd_duty  = '0;
        cmd_periods = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(negedge clk);
        obs = {dir_out, drive_en, busy, done, cmd_ready};
        checks++;
        if (obs !== 6'b00_0001) begin
            errors++;
            $display("FAIL reset: dir/en/busy/done/ready got %b expected %b", obs, 6'b00_0001);
        end
        @(posedge clk);
        #1;
        m_dir = 2'd0;
        m_eff = 0;
    endtask

    task automatic run_from_idle(input string name, input logic [1:0] d, input int duty,
                                 input int per);
        logic [5:0] exp, obs;
        int cyc = 0;
        exp_q.delete();
        push(m_dir, 1'b0, 1'b0, 1'b0, 1'b1);
        if (d != m_dir) push_dead(m_dir);
        m_dir = d;
        m_eff = RAMP ? 0 : duty;
        push_run(d, duty, per, 1'b1);
        push(d, 1'b0, 1'b0, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            if (cyc == 0) drive_cmd(d, duty, per);
            @(negedge clk);
            exp = exp_q.pop_front();
            obs = {dir_out, drive_en, busy, done, cmd_ready};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: dir/en/busy/done/ready got %b expected %b",
                         name, cyc, obs, exp);
            end
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            cyc++;
        end
    endtask

    task automatic test_dir_change;
        run_from_idle("dir_change", DIR_FWD, 4, 3);
    endtask

    task automatic test_random_cmds;
        for (int n = 0; n < 8; n++) begin
            run_from_idle("random_cmd", 2'($urandom_range(3, 0)), int'($urandom_range(15, 0)),
                          int'($urandom_range(2, 1)));
        end
    endtask

    task automatic test_replace;
        logic [5:0] exp, obs;
        int cyc = 0;
        int issue_at;
        int d0 = int'($urandom_range(15, 0));
        exp_q.delete();
        push(m_dir, 1'b0, 1'b0, 1'b0, 1'b1);
        if (m_dir != DIR_FWD) push_dead(m_dir);
        m_dir = DIR_FWD;
        m_eff = RAMP ? 0 : d0;
        push_run(DIR_FWD, d0, 1, 1'b0);
        push_partial(DIR_FWD, 5);
        issue_at = exp_q.size() - 1;
        m_eff = RAMP ? m_eff : 12;
        push_run(DIR_FWD, 12, 1, 1'b1);
        push(DIR_FWD, 1'b0, 1'b0, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            if (cyc == 0) drive_cmd(DIR_FWD, d0, 0);
            if (cyc == issue_at) drive_cmd(DIR_FWD, 12, 1);
            @(negedge clk);
            exp = exp_q.pop_front();
            obs = {dir_out, drive_en, busy, done, cmd_ready};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL replace cycle %0d: dir/en/busy/done/ready got %b expected %b",
                         cyc, obs, exp);
            end
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            cyc++;
        end
    endtask

    task automatic test_dir_swap;
        logic [5:0] exp, obs;
        int cyc = 0;
        int issue_at;
        int d0 = int'($urandom_range(15, 1));
        exp_q.delete();
        push(m_dir, 1'b0, 1'b0, 1'b0, 1'b1);
        if (m_dir != DIR_FWD) push_dead(m_dir);
        m_dir = DIR_FWD;
        m_eff = RAMP ? 0 : d0;
        push_run(DIR_FWD, d0, 1, 1'b0);
        push_partial(DIR_FWD, 3);
        issue_at = exp_q.size() - 1;
        push_dead(DIR_FWD);
        m_dir = DIR_REV;
        m_eff = RAMP ? 0 : 7;
        push_run(DIR_REV, 7, 1, 1'b1);
        push(DIR_REV, 1'b0, 1'b0, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            if (cyc == 0) drive_cmd(DIR_FWD, d0, 0);
            if (cyc == issue_at) drive_cmd(DIR_REV, 7, 1);
            @(negedge clk);
            exp = exp_q.pop_front();
            obs = {dir_out, drive_en, busy, done, cmd_ready};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL dir_swap cycle %0d: dir/en/busy/done/ready got %b expected %b",
                         cyc, obs, exp);
            end
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            cyc++;
        end
    endtask

    task automatic test_stop;
        logic [5:0] exp, obs;
        int cyc = 0;
        int stop_at;
        int idle_stop_at;
        exp_q.delete();
        push(m_dir, 1'b0, 1'b0, 1'b0, 1'b1);
        if (m_dir != DIR_REV) push_dead(m_dir);
        m_dir = DIR_REV;
        m_eff = RAMP ? 0 : 9;
        push_partial(DIR_REV, 9);
        stop_at = exp_q.size();
        push(DIR_REV, 9 < m_eff, 1'b1, 1'b0, 1'b0);
        push_dead(DIR_REV);
        repeat (3) push(DIR_REV, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_stop_at = exp_q.size();
        push(DIR_REV, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) push(DIR_REV, 1'b0, 1'b0, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            if (cyc == 0) drive_cmd(DIR_REV, 9, 0);
            if (cyc == stop_at || cyc == idle_stop_at) begin
                stop = 1'b1;
                drive_cmd(DIR_SPIN_L, 5, 1);
            end
            if (cyc == stop_at + 3) stop = 1'b1;
            @(negedge clk);
            exp = exp_q.pop_front();
            obs = {dir_out, drive_en, busy, done, cmd_ready};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stop cycle %0d: dir/en/busy/done/ready got %b expected %b",
                         cyc, obs, exp);
            end
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            stop      = 1'b0;
            cyc++;
        end
    endtask

    task automatic test_reset_midrun;
        logic [5:0] exp, obs;
        int cyc = 0;
        int rst_at;
        exp_q.delete();
        push(m_dir, 1'b0, 1'b0, 1'b0, 1'b1);
        m_eff = RAMP ? 0 : 15;
        push_partial(m_dir, 6);
        rst_at = exp_q.size() - 1;
        repeat (2) push(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            if (cyc == 0) drive_cmd(m_dir, 15, 0);
            if (cyc == rst_at) reset = 1'b1;
            @(negedge clk);
            exp = exp_q.pop_front();
            obs = {dir_out, drive_en, busy, done, cmd_ready};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_midrun cycle %0d: dir/en/busy/done/ready got %b expected %b",
                         cyc, obs, exp);
            end
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            reset     = 1'b0;
            cyc++;
        end
        m_dir = 2'd0;
    endtask

`ifdef MOTOR_SEQ_RAMP_EN
    task automatic test_ramp;
        int want[5] = '{0, 4, 8, 12, 12};
        int hi;
        drive_cmd(m_dir, 12, 5);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int p = 0; p < 5; p++) begin
            hi = 0;
            for (int k = 0; k < PERIOD; k++) begin
                @(negedge clk);
                hi += int'(drive_en);
                @(posedge clk);
                #1;
            end
            checks++;
            if (hi != want[p]) begin
                errors++;
                $display("FAIL ramp period %0d: high cycles got %0d expected %0d", p, hi, want[p]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ramp done: got %b expected 1", done);
        end
        @(posedge clk);
        #1;
        drive_cmd(m_dir, 0, 2);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        hi = 0;
        for (int k = 0; k < 2 * PERIOD; k++) begin
            @(negedge clk);
            hi += int'(drive_en);
            @(posedge clk);
            #1;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL ramp duty0: high cycles got %0d expected 0", hi);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ramp duty0 done: got %b expected 1", done);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_dir_change();
        test_random_cmds();
        test_replace();
        test_dir_swap();
        test_stop();
        test_reset_midrun();
`ifdef MOTOR_SEQ_RAMP_EN
        test_ramp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
